// File: rtl/mic_capture_sequencer_pkg.sv
// Shared definitions for the microphone capture sequencer.
//   - FSM state encoding
//   - channel-select encoding
//   - default sample width and capture FIFO depth
package mic_capture_sequencer_pkg;

    localparam int SAMPLE_W_DEF   = 24;
    localparam int FIFO_DEPTH_DEF = 64;

    localparam logic [1:0] CHAN_LEFT  = 2'd0;
    localparam logic [1:0] CHAN_RIGHT = 2'd1;
    localparam logic [1:0] CHAN_BOTH  = 2'd2;  // left then right
    localparam logic [1:0] CHAN_RSVD  = 2'd3;  // behaves as CHAN_LEFT

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mic_capture_sequencer_sync_fifo.sv
// Single-clock FIFO holding {last, data} capture entries.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   flush_i         empties the FIFO (wins over push/pop)
//   push_i/data_i   write request; accepted when not full or when a pop
//                   frees a slot in the same cycle
//   tag_tail_i      set the MSB (last tag) of the most recently written entry
//   pop_i           read request, ignored when empty
//   head_o          head entry, forced to zero while empty
//   full_o, empty_o status flags
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             tag_tail_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW-1:0]    wr_idx, rd_idx, tail_idx;
    logic             pop_en, push_en;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign tail_idx = wr_idx - IDX_ONE;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    // Pop is evaluated first so a full FIFO can still accept a push.
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    assign head_o = empty_o ? '0 : mem[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (push_en)    mem[wr_idx] <= data_i;
            if (tag_tail_i) mem[tail_idx][WIDTH-1] <= 1'b1;
        end
    end

endmodule

// File: rtl/mic_capture_sequencer.sv
// Microphone capture sequencer: arms on start, decimates incoming stereo
// strobes, pushes selected channel words into a capture FIFO and streams
// them out with a last marker on the final entry of the run.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   start_i, abort_i            run control pulses
//   num_samples_i, decim_i,
//   chan_sel_i                  run configuration, latched on start
//   sample_stb_i, left_i,
//   right_i                     sample source
//   out_valid_o, out_ready_i,
//   out_data_o, out_last_o      output stream (FIFO head)
//   busy_o, done_o, overflow_o  status
module mic_capture_sequencer
    import mic_capture_sequencer_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [15:0]         num_samples_i,
    input  logic [3:0]          decim_i,
    input  logic [1:0]          chan_sel_i,
    input  logic                sample_stb_i,
    input  logic [SAMPLE_W-1:0] left_i,
    input  logic [SAMPLE_W-1:0] right_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [SAMPLE_W-1:0] out_data_o,
    output logic                out_last_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o
);

    state_t              state;
    logic                busy_q, done_q, ovf_q;
    logic [15:0]         num_q, cnt;
    logic [3:0]          decim_q, decim_cnt;
    logic [1:0]          chan_q;
    logic                pend_right;
    logic [SAMPLE_W-1:0] right_q;

    logic                active, kept, push_req, push_drop, push_is_last;
    logic                pop, flush, tag_tail;
    logic [15:0]         cnt_next;
    logic [SAMPLE_W-1:0] push_data;
    logic [SAMPLE_W:0]   head;
    logic                fifo_full, fifo_empty;

    assign active   = (state == ST_ARM) || (state == ST_CAPTURE);
    assign kept     = active && sample_stb_i && (decim_cnt == 4'd0);
    assign push_req = !abort_i && (kept || ((state == ST_CAPTURE) && pend_right));
    assign cnt_next = cnt + 16'd1;
    assign push_is_last = (cnt_next == num_q);

    // The held right word goes out in the cycle after its strobe; strobes
    // are at least two cycles apart so it never collides with a new one.
    assign push_data = pend_right            ? right_q :
                       (chan_q == CHAN_RIGHT) ? right_i : left_i;

    assign pop       = out_valid_o && out_ready_i;
    assign push_drop = push_req && fifo_full && !pop;
    assign flush     = abort_i && (state != ST_IDLE);
    // A dropped final push moves its last tag to the newest stored entry.
    assign tag_tail  = push_drop && push_is_last && !fifo_empty;

    sync_fifo #(
        .WIDTH (SAMPLE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush),
        .push_i     (push_req),
        .data_i     ({push_is_last, push_data}),
        .tag_tail_i (tag_tail),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = head[SAMPLE_W-1:0];
    assign out_last_o  = head[SAMPLE_W];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            num_q      <= '0;
            cnt        <= '0;
            decim_q    <= '0;
            decim_cnt  <= '0;
            chan_q     <= CHAN_LEFT;
            pend_right <= 1'b0;
            right_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        num_q      <= num_samples_i;
                        decim_q    <= decim_i;
                        chan_q     <= chan_sel_i;
                        ovf_q      <= 1'b0;
                        cnt        <= '0;
                        decim_cnt  <= '0;
                        pend_right <= 1'b0;
                        busy_q     <= 1'b1;
                        if (num_samples_i == 16'd0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_ARM;
                        end
                    end
                end
                ST_ARM, ST_CAPTURE: begin
                    if (abort_i) begin
                        state      <= ST_IDLE;
                        busy_q     <= 1'b0;
                        pend_right <= 1'b0;
                    end else begin
                        if (sample_stb_i) begin
                            decim_cnt <= (decim_cnt == decim_q) ? 4'd0 : decim_cnt + 4'd1;
                            state     <= ST_CAPTURE;
                        end
                        // Only a non-final left push leaves a right word pending.
                        pend_right <= kept && (chan_q == CHAN_BOTH) && !push_is_last;
                        if (kept) right_q <= right_i;
                        if (push_req) begin
                            cnt <= cnt_next;
                            if (push_drop) ovf_q <= 1'b1;
                            if (push_is_last) begin
                                if (push_drop && fifo_empty) begin
                                    state  <= ST_DONE;
                                    done_q <= 1'b1;
                                end else begin
                                    state  <= ST_DRAIN;
                                end
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort_i) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (pop && out_last_o) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
